// File: rtl/seg_pkg.sv
// seg_pkg: segment codes, FSM state encoding and digit count shared by the capture decoder.
`default_nettype none

package seg_pkg;

  localparam int NUM_DIGITS_C = 4;

  // Active-low codes on seg_in[7:1] = {a,b,c,d,e,f,g}
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001101;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    HELD  = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/seg7_decode.sv
// seg7_decode: combinational map from an active-low 7-segment pattern to {bcd, blank, err}.
`default_nettype none

module seg7_decode
  import seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] bcd,
  output logic       blank,
  output logic       err
);

  always_comb begin
    bcd   = 4'hF;
    blank = 1'b0;
    err   = 1'b0;
    case (seg)
      SEG_0:     bcd = 4'd0;
      SEG_1:     bcd = 4'd1;
      SEG_2:     bcd = 4'd2;
      SEG_3:     bcd = 4'd3;
      SEG_4:     bcd = 4'd4;
      SEG_5:     bcd = 4'd5;
      SEG_6:     bcd = 4'd6;
      SEG_7:     bcd = 4'd7;
      SEG_8:     bcd = 4'd8;
      SEG_9:     bcd = 4'd9;
      SEG_BLANK: blank = 1'b1;
      default:   err = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/seg_capture_decoder.sv
// seg_capture_decoder: debounces a multiplexed 7-segment bus and captures each digit as BCD.
// Optional macro SEG_CAPTURE_DP_EN enables per-digit decimal-point capture.
`default_nettype none

module seg_capture_decoder
  import seg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int NUM_DIGITS    = NUM_DIGITS_C
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic [NUM_DIGITS-1:0]   dp_out,
  output logic [NUM_DIGITS-1:0]   blank,
  output logic [NUM_DIGITS-1:0]   err,
  output logic                    frame_valid
);

`ifdef SEG_CAPTURE_DP_EN
  localparam logic [7:0] CMP_MASK = 8'hFF;
`else
  localparam logic [7:0] CMP_MASK = 8'hFE;
`endif
  localparam logic [7:0]            CNT_LAST  = 8'(STABLE_CYCLES - 1);
  localparam logic [7:0]            CNT_FULL  = 8'(STABLE_CYCLES);
  localparam logic [NUM_DIGITS-1:0] MASK_FULL = {NUM_DIGITS{1'b1}};

  logic [7:0]            seg_q, seg_p;
  logic [NUM_DIGITS-1:0] en_q, en_p;
  state_t                state, state_nxt;
  logic [7:0]            cnt, cnt_nxt;
  logic                  capture;
  logic [NUM_DIGITS-1:0] mask;
  logic                  one_hot, same;
  logic [3:0]            dec_bcd;
  logic                  dec_blank, dec_err;

  assign one_hot = (en_q != '0) && ((en_q & (en_q - 1'b1)) == '0);
  assign same    = (((seg_q ^ seg_p) & CMP_MASK) == 8'h00) && (en_q == en_p);

  // seg_p/en_p hold the previous sample so stability is judged on registered data only
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q <= '0;
      seg_p <= '0;
      en_q  <= '0;
      en_p  <= '0;
    end else begin
      seg_q <= seg_in;
      seg_p <= seg_q;
      en_q  <= digit_en;
      en_p  <= en_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (one_hot) begin
          state_nxt = TRACK;
          cnt_nxt   = 8'd1;
        end else begin
          cnt_nxt = 8'd0;
        end
      end
      TRACK: begin
        if (!one_hot) begin
          state_nxt = IDLE;
          cnt_nxt   = 8'd0;
        end else if (!same) begin
          cnt_nxt = 8'd1;
        end else if (cnt == CNT_LAST) begin
          state_nxt = HELD;
          cnt_nxt   = CNT_FULL;
          capture   = 1'b1;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      HELD: begin
        if (!one_hot) begin
          state_nxt = IDLE;
          cnt_nxt   = 8'd0;
        end else if (!same) begin
          state_nxt = TRACK;
          cnt_nxt   = 8'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 8'd0;
      end
    endcase
  end

  seg7_decode u_dec (
    .seg   (seg_q[7:1]),
    .bcd   (dec_bcd),
    .blank (dec_blank),
    .err   (dec_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      bcd_out <= '1;
      blank   <= '1;
      err     <= '0;
    end else if (capture) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (en_q[i]) begin
          bcd_out[4*i +: 4] <= dec_bcd;
          blank[i]          <= dec_blank;
          err[i]            <= dec_err;
        end
      end
    end
  end

`ifdef SEG_CAPTURE_DP_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      dp_out <= '0;
    end else if (capture) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (en_q[i]) dp_out[i] <= ~seg_q[0];
      end
    end
  end
`else
  assign dp_out = '0;
`endif

  // A full mask clears on the pulse edge, while a same-edge capture still lands in it
  always_ff @(posedge clk) begin
    if (rst) begin
      mask        <= '0;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= (mask == MASK_FULL);
      mask        <= ((mask == MASK_FULL) ? '0 : mask) | (capture ? en_q : '0);
    end
  end

endmodule

`default_nettype wire
